jk_reg_bank: RTL and testbench
==============================

# jk_reg_bank

Parametrised bank of WIDTH JK flip-flops sharing one clock, with complementary outputs, a synchronous reset and a clock enable. A mode select reuses the same storage as an independent JK array, a synchronous binary up counter, a down counter, or a serial shift register. It is the multi-bit successor to the single-bit JK cell and is used wherever the lab designs need counters or shift registers built from JK behaviour.

## Interface

Parameters:
- WIDTH, default 4: number of JK cells; legal range 2..32.
- RESET_VAL, default 0: WIDTH-bit value loaded into q on reset.

Ports:
- clk, input, 1: rising-edge clock; the only clock.
- rst, input, 1: synchronous, active-high reset; sampled on posedge clk.
- en, input, 1: clock enable; 0 means hold all state.
- mode, input, 2: operating mode, decoded below.
- j, input, WIDTH: per-bit J inputs; in shift mode j[0] is the serial input.
- k, input, WIDTH: per-bit K inputs; used only in mode 00.
- q, output, WIDTH: registered state.
- qb, output, WIDTH: registered complement of q; always equals ~q.
- tc, output, 1: combinational terminal-count flag.
- so, output, 1: serial out, equal to q[WIDTH-1].

## Operation

- Reset:
  - On posedge clk with rst=1: q <= RESET_VAL and qb <= ~RESET_VAL.
  - rst overrides en, mode, j and k.
  - There is no asynchronous path and no initial-block dependence. Before the first reset edge, state is X.
- Hold: with rst=0 and en=0, q and qb are unchanged regardless of mode, j and k.
- With rst=0 and en=1, each posedge applies the current mode.
- Mode 00, JK array. Per bit i, from (j[i], k[i]):
  - 00: hold.
  - 01: q[i] <= 0.
  - 10: q[i] <= 1.
  - 11: q[i] <= ~q[i].
- Mode 01, up counter:
  - Bit i toggles when all bits below i are 1; bit 0 always toggles. This equals q <= q + 1 modulo 2^WIDTH.
  - All-ones wraps to all-zeros.
  - j and k are ignored.
- Mode 10, down counter:
  - Bit i toggles when all bits below i are 0. This equals q <= q - 1 modulo 2^WIDTH.
  - All-zeros wraps to all-ones.
  - j and k are ignored.
- Mode 11, shift left: q <= {q[WIDTH-2:0], j[0]}. j[WIDTH-1:1] and all of k are ignored.
- qb invariant: qb is registered in the same always block as q and equals ~q after every edge, including reset.
- tc (combinational):
  - Mode 01: tc = en & (q == all ones).
  - Mode 10: tc = en & (q == 0).
  - Modes 00 and 11: tc = 0.
  - tc is forced to 0 while rst=1.
- Mode changes take effect on the next edge with no state flush; the count or shift continues from the current q.
- Width rules:
  - All arithmetic is exactly WIDTH bits.
  - Toggle enables are formed from prefix AND/NOR of q, not from a wider adder.
  - No carry out beyond tc.

## Timing

- Latency from inputs to q/qb: 1 clock edge. All inputs are sampled at posedge clk.
- tc and so follow q combinationally, within the same cycle as the q that produced them.
- In mode 01, tc is high during the cycle in which the next edge wraps the counter. It can be used directly as a cascade enable for a downstream bank.
- Reset mid-operation (count or shift in progress) returns q to RESET_VAL on that edge. The next edge with en=1 resumes from RESET_VAL in the current mode.
- Simultaneous rst=1 and en=1 with any mode: the reset value wins.
- No combinational path exists from j or k to any output.

## Test plan

Use WIDTH=4 and RESET_VAL=4'b0000 unless stated.

1. Reset and hold:
   - Stimulus: assert rst for 1 edge, then rst=0, en=0, mode=00, j=4'hF, k=4'h0 for 3 edges.
   - Required: q=0000 and qb=1111 after reset, unchanged through the 3 hold edges; tc=0.
2. JK truth table per bit:
   - Stimulus: from q=0000, mode=00, en=1, apply (j,k) = (0011,0000), then (0000,0001), then (1111,1111), then (0101,1010).
   - Required: q=0011, then 0010, then 1101, then 0101; qb=~q after every edge.
3. Up count and wrap:
   - Stimulus: mode=01, en=1, 17 edges from reset.
   - Required: q steps 0001 through 1111, then 0000, then 0001.
   - Required: tc=1 only while q=1111.
4. Down count and wrap:
   - Stimulus: reset, then mode=10, en=1.
   - Required: tc=1 at q=0000 before the first edge; first edge gives q=1111, then 1110.
   - Required: tc=0 until q returns to 0000 after 16 edges.
5. Shift and serial out:
   - Stimulus: mode=11, en=1, feed j[0] = 1,0,1,1 over 4 edges.
   - Required: q=1011 after the 4 edges; so=1; k ignored (drive k random and confirm no effect).
6. Reset mid-count and non-zero RESET_VAL:
   - Stimulus: set RESET_VAL=4'b1010, mode=01, count to q=1100, then assert rst together with en=1.
   - Required: q=1010 and qb=0101 on that edge; the next edge gives 1011.

Source files
------------

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops whose shared storage can also act as an up/down
// counter or a left shift register, selected by mode. q and qb are registered together.
module jk_reg_bank #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             so
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_SHL  = 2'b11;

  logic [WIDTH-1:0] q_q, qb_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] ones_below, zeros_below;

  // Ripple prefix AND/NOR gives each bit its counter toggle enable.
  always_comb begin
    ones_below     = '0;
    zeros_below    = '0;
    ones_below[0]  = 1'b1;
    zeros_below[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      ones_below[i]  = ones_below[i-1] & q_q[i-1];
      zeros_below[i] = zeros_below[i-1] & ~q_q[i-1];
    end
  end

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        MODE_JK: begin
          for (int i = 0; i < WIDTH; i++) begin
            case ({j[i], k[i]})
              2'b01:   q_d[i] = 1'b0;
              2'b10:   q_d[i] = 1'b1;
              2'b11:   q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
        end
        MODE_UP:   q_d = q_q ^ ones_below;
        MODE_DOWN: q_d = q_q ^ zeros_below;
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], j[0]};
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= RESET_VAL;
      qb_q <= ~RESET_VAL;
    end else begin
      q_q  <= q_d;
      qb_q <= ~q_d;
    end
  end

  always_comb begin
    tc = 1'b0;
    if (!rst && en) begin
      if (mode == MODE_UP)   tc = &q_q;
      if (mode == MODE_DOWN) tc = ~|q_q;
    end
  end

  assign q  = q_q;
  assign qb = qb_q;
  assign so = q_q[WIDTH-1];

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench: two banks (reset value 0000 and 1010) driven in parallel,
// checked every cycle against an arithmetic model plus directed literal checks.
module tb_jk_reg_bank;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] j = '0;
  logic [W-1:0] k = '0;
  logic [W-1:0] q0, qb0, q1, qb1;
  logic         tc0, so0, tc1, so1;

  int checks = 0;
  int errors = 0;
  int m0, m1;
  bit valid = 1'b0;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(4'b0000)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
    .q(q0), .qb(qb0), .tc(tc0), .so(so0));

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(4'b1010)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
    .q(q1), .qb(qb1), .tc(tc1), .so(so1));

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference behaviour as plain integer arithmetic mod 16.
  function automatic int model_next(int cur, int rv);
    int jv, kv, r;
    if (rst) return rv;
    if (!en) return cur;
    jv = int'(j);
    kv = int'(k);
    case (mode)
      2'd0: r = (jv & ~cur) | (~kv & cur);
      2'd1: r = cur + 1;
      2'd2: r = cur + 15;
      default: r = (cur * 2) + (jv % 2);
    endcase
    return r % 16;
  endfunction

  function automatic int model_tc(int cur);
    if (rst || !en) return 0;
    if (mode == 2'd1) return (cur == 15) ? 1 : 0;
    if (mode == 2'd2) return (cur == 0) ? 1 : 0;
    return 0;
  endfunction

  always @(posedge clk) begin
    m0 = model_next(m0, 0);
    m1 = model_next(m1, 10);
    if (rst) valid = 1'b1;
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("q0", int'(q0), m0);
      chk("qb0", int'(qb0), 15 - m0);
      chk("tc0", int'(tc0), model_tc(m0));
      chk("so0", int'(so0), m0 / 8);
      chk("q1", int'(q1), m1);
      chk("qb1", int'(qb1), 15 - m1);
      chk("tc1", int'(tc1), model_tc(m1));
      chk("so1", int'(so1), m1 / 8);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int seq [4];
    m0 = 0;
    m1 = 0;
    #2;

    // 1. reset and hold
    en = 1'b1; mode = 2'b01; j = 4'hF; k = 4'hF;
    do_reset();
    chk("rst_q", int'(q0), 0);
    chk("rst_qb", int'(qb0), 15);
    en = 1'b0; mode = 2'b00; j = 4'hF; k = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_q", int'(q0), 0);
      chk("hold_qb", int'(qb0), 15);
      chk("hold_tc", int'(tc0), 0);
    end

    // 2. JK truth table
    en = 1'b1; mode = 2'b00;
    j = 4'b0011; k = 4'b0000; step(); chk("jk1", int'(q0), 4'b0011);
    j = 4'b0000; k = 4'b0001; step(); chk("jk2", int'(q0), 4'b0010);
    j = 4'b1111; k = 4'b1111; step(); chk("jk3", int'(q0), 4'b1101);
    chk("jk3_qb", int'(qb0), 4'b0010);
    j = 4'b0101; k = 4'b1010; step(); chk("jk4", int'(q0), 4'b0101);

    // 3. up count with wrap
    do_reset();
    mode = 2'b01; en = 1'b1; j = 4'h0; k = 4'h0;
    for (int i = 0; i < 17; i++) begin
      chk("up_tc", int'(tc0), (i == 15) ? 1 : 0);
      step();
      chk("up_q", int'(q0), (i + 1) % 16);
    end

    // 4. down count with wrap
    en = 1'b0;
    do_reset();
    mode = 2'b10; en = 1'b1;
    #1;
    chk("dn_tc0", int'(tc0), 1);
    step(); chk("dn_q1", int'(q0), 4'b1111);
    chk("dn_tc1", int'(tc0), 0);
    step(); chk("dn_q2", int'(q0), 4'b1110);
    for (int i = 2; i < 16; i++) step();
    chk("dn_q16", int'(q0), 0);
    chk("dn_tc16", int'(tc0), 1);

    // 5. shift with random k
    do_reset();
    mode = 2'b11; en = 1'b1;
    seq = '{1, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      j = {3'($urandom), 1'(seq[i])};
      k = 4'($urandom);
      step();
    end
    chk("sh_q", int'(q0), 4'b1011);
    chk("sh_so", int'(so0), 1);

    // 6. mid-count reset on the 1010 bank
    do_reset();
    mode = 2'b01; en = 1'b1;
    step(); step();
    chk("rv_cnt", int'(q1), 4'b1100);
    rst = 1'b1;
    step();
    chk("rv_q", int'(q1), 4'b1010);
    chk("rv_qb", int'(qb1), 4'b0101);
    rst = 1'b0;
    step();
    chk("rv_next", int'(q1), 4'b1011);

    // random traffic, continuously checked by the compare process
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 19) == 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom);
      j    = 4'($urandom);
      k    = 4'($urandom);
      step();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
